// File: rtl/logic_pipe_stage_pkg.sv
// logic_pipe_stage_pkg: opcodes, queue depth and queue state type shared by the logic stage
package logic_pipe_stage_pkg;
  localparam logic [2:0] LOGIC_AND    = 3'b000;
  localparam logic [2:0] LOGIC_OR     = 3'b001;
  localparam logic [2:0] LOGIC_NOR    = 3'b010;
  localparam logic [2:0] LOGIC_INV_A  = 3'b011;
  localparam logic [2:0] LOGIC_INV_B  = 3'b100;
  localparam logic [2:0] LOGIC_PASS_A = 3'b101;
  localparam int QUEUE_DEPTH = 2;
  typedef enum logic [1:0] {Q_EMPTY = 2'd0, Q_ONE = 2'd1, Q_TWO = 2'(QUEUE_DEPTH)} q_state_t;
  function automatic logic is_legal(input logic [2:0] oprn);
    return oprn <= LOGIC_PASS_A;
  endfunction
endpackage

// File: rtl/logic_pipe_stage_if.sv
// logic_pipe_stage_if: op request handshake, result handshake and op counter of the logic stage
interface logic_pipe_stage_if #(parameter int DATA_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            oprn;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  err;
  logic [15:0]           op_count;
  modport master(output in_valid, oprn, op1, op2, out_ready,
                 input in_ready, out_valid, result, zero, err, op_count);
  modport slave(input in_valid, oprn, op1, op2, out_ready,
                output in_ready, out_valid, result, zero, err, op_count);
endinterface

// File: rtl/logic_pipe_stage_gates.sv
// logic_pipe_stage_gates: 32-bit gate arrays; ports Y (out), A/B (in)
module AND32_2x1(output logic [31:0] Y, input logic [31:0] A, input logic [31:0] B);
  assign Y = A & B;
endmodule

module OR32_2x1(output logic [31:0] Y, input logic [31:0] A, input logic [31:0] B);
  assign Y = A | B;
endmodule

module NOR32_2x1(output logic [31:0] Y, input logic [31:0] A, input logic [31:0] B);
  assign Y = ~(A | B);
endmodule

module INV32_1x1(output logic [31:0] Y, input logic [31:0] A);
  assign Y = ~A;
endmodule

// File: rtl/logic_result_queue.sv
// logic_result_queue: 2-entry skid FIFO; ports clk, rst, push, pop, din, head (registered), count
module logic_result_queue
  import logic_pipe_stage_pkg::*;
#(parameter int W = 34) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output q_state_t     count
);
  logic [W-1:0] tail;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= Q_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        Q_EMPTY: if (push) begin
          head  <= din;
          count <= Q_ONE;
        end
        Q_ONE: begin
          if (push && pop) head <= din;
          else if (push) begin
            tail  <= din;
            count <= Q_TWO;
          end else if (pop) count <= Q_EMPTY;
        end
        Q_TWO: if (pop) begin
          head  <= tail;
          count <= Q_ONE;
        end
        default: count <= Q_EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage: logic op stage; ports CLK, RST, bus (op request in, queued RESULT/ZERO/ERR out, op_count)
module logic_pipe_stage
  import logic_pipe_stage_pkg::*;
#(parameter int DATA_WIDTH = 32) (
  input logic               CLK,
  input logic               RST,
  logic_pipe_stage_if.slave bus
);
  logic [DATA_WIDTH-1:0] and_y, or_y, nor_y, inv_a, inv_b, res;
  logic [15:0] op_count;
  logic accept, pop, legal;
  q_state_t count;
  AND32_2x1 u_and(.Y(and_y), .A(bus.op1), .B(bus.op2));
  OR32_2x1  u_or (.Y(or_y),  .A(bus.op1), .B(bus.op2));
  NOR32_2x1 u_nor(.Y(nor_y), .A(bus.op1), .B(bus.op2));
  INV32_1x1 u_inv_a(.Y(inv_a), .A(bus.op1));
  INV32_1x1 u_inv_b(.Y(inv_b), .A(bus.op2));
  assign legal = is_legal(bus.oprn);
  always_comb begin
    res = bus.oprn == LOGIC_AND   ? and_y :
          bus.oprn == LOGIC_OR    ? or_y  :
          bus.oprn == LOGIC_NOR   ? nor_y :
          bus.oprn == LOGIC_INV_A ? inv_a :
          bus.oprn == LOGIC_INV_B ? inv_b :
          bus.oprn == LOGIC_PASS_A ? bus.op1 : '0;
  end
  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;
  logic_result_queue #(.W(DATA_WIDTH + 2)) u_queue (
    .clk(CLK),
    .rst(RST),
    .push(accept),
    .pop(pop),
    .din({~legal, ~|res, res}),
    .head({bus.err, bus.zero, bus.result}),
    .count(count)
  );
  // readiness depends only on queue state and reset, never on out_ready
  assign bus.in_ready  = (count != Q_TWO) & ~RST;
  assign bus.out_valid = count != Q_EMPTY;
  assign bus.op_count  = op_count;
  always_ff @(posedge CLK) begin
    if (RST) op_count <= '0;
    else if (accept) op_count <= op_count + 16'd1;
  end
endmodule

// File: tb/tb_logic_pipe_stage.sv
// tb_logic_pipe_stage: directed bench with a FIFO reference model for logic_pipe_stage
module tb_logic_pipe_stage;
  logic clk = 0, rst = 1, armed = 0;
  int errors = 0, checks = 0;
  logic [33:0] q[$];
  logic [15:0] cnt = 0;
  logic_pipe_stage_if #(.DATA_WIDTH(32)) bus();
  logic_pipe_stage #(.DATA_WIDTH(32)) dut(.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [33:0] expect_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~(a | b);
      3'd3: r = ~a;
      3'd4: r = ~b;
      3'd5: r = a;
      default: r = 32'd0;
    endcase
    return {op > 3'd5, r == 32'd0, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    int n;
    n = q.size();
    if (rst) begin
      q.delete();
      cnt = 0;
    end else begin
      if (bus.out_ready && n > 0) void'(q.pop_front());
      if (bus.in_valid && n < 2) begin
        q.push_back(expect_of(bus.oprn, bus.op1, bus.op2));
        cnt++;
      end
    end
  end

  always @(negedge clk) if (armed) begin
    check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) check("head", 64'({bus.err, bus.zero, bus.result}), 64'(q[0]));
    check("in_ready", 64'(bus.in_ready), 64'(!rst && q.size() < 2));
    check("op_count", 64'(bus.op_count), 64'(cnt));
  end

  initial begin
    bus.in_valid = 0; bus.out_ready = 1; bus.oprn = 0; bus.op1 = 0; bus.op2 = 0;
    cyc(); cyc();
    armed = 1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 0; #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1; bus.op1 = 32'h0a17b980; bus.op2 = 32'h11af6077;
    bus.oprn = 3'd0; cyc();
    check("and", 64'(bus.result), 64'h00072000);
    bus.oprn = 3'd1; cyc();
    check("or", 64'(bus.result), 64'h1bbff9f7);
    bus.oprn = 3'd2; cyc();
    check("nor", 64'(bus.result), 64'he4400608);
    bus.in_valid = 0; cyc();
    bus.in_valid = 1; bus.oprn = 3'd3; bus.op1 = 32'hffffffff; cyc();
    check("inv_a", 64'({bus.zero, bus.result}), {31'd0, 1'b1, 32'h00000000});
    bus.oprn = 3'd4; bus.op2 = 32'h0; cyc();
    check("inv_b", 64'({bus.zero, bus.result}), {31'd0, 1'b0, 32'hffffffff});
    bus.in_valid = 0; cyc();
    bus.out_ready = 0; bus.in_valid = 1; bus.oprn = 3'd5;
    bus.op1 = 32'd1; cyc();
    bus.op1 = 32'd2; cyc();
    check("bp_full_ready", 64'(bus.in_ready), 64'd0);
    bus.op1 = 32'd3; cyc();
    check("bp_stable1", 64'(bus.result), 64'd1);
    cyc();
    check("bp_stable2", 64'(bus.result), 64'd1);
    check("bp_count", 64'(bus.op_count), 64'd7);
    bus.out_ready = 1; cyc();
    check("drain_second", 64'(bus.result), 64'd2);
    cyc();
    bus.in_valid = 0;
    check("skid_head", 64'(bus.result), 64'd3);
    check("skid_one", 64'({bus.out_valid, bus.in_ready}), 64'b11);
    check("skid_count", 64'(bus.op_count), 64'd8);
    cyc();
    bus.out_ready = 0; bus.in_valid = 1; bus.oprn = 3'd0; cyc(); cyc();
    bus.in_valid = 0; rst = 1; cyc(); cyc();
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_result", 64'(bus.result), 64'd0);
    check("mid_rst_count", 64'(bus.op_count), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    rst = 0; bus.out_ready = 1; #1;
    check("after_rst_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    check("after_rst_empty", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1; bus.oprn = 3'b111; bus.op1 = 32'h1234; bus.op2 = 32'h5678; cyc();
    check("illegal", 64'({bus.err, bus.zero, bus.result}), {30'd0, 2'b11, 32'd0});
    while (cnt != 16'hffff) begin
      bus.oprn = 3'($urandom_range(0, 7)); bus.op1 = $urandom; bus.op2 = $urandom;
      cyc();
    end
    check("pre_wrap", 64'(bus.op_count), 64'hffff);
    cyc();
    check("wrap", 64'(bus.op_count), 64'd0);
    bus.in_valid = 0; cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logic_pipe_stage.md
# logic_pipe_stage

Registered, handshaked output stage for the 32-bit logic datapath. It accepts an operation code and two operands, and evaluates them through the combinational NOR/AND/OR/INV gate arrays. It then buffers each result, with a zero flag, in a 2-entry skid queue for the downstream consumer (ALU result mux / writeback). It decouples the combinational gate network from a consumer that can stall.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width (only 32 is verified)

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  reset; synchronous to CLK, active-high
- IN_VALID  in  1  upstream presents OPRN/OP1/OP2
- IN_READY  out  1  stage can accept this cycle
- OPRN  in  3  logic operation select
- OP1  in  DATA_WIDTH  operand A
- OP2  in  DATA_WIDTH  operand B
- OUT_VALID  out  1  RESULT/ZERO/ERR hold a valid entry
- OUT_READY  in  1  downstream consumes the head entry this cycle
- RESULT  out  DATA_WIDTH  head-entry result
- ZERO  out  1  head RESULT == 0
- ERR  out  1  head entry came from an illegal OPRN
- OP_COUNT  out  16  number of accepted operations, wraps at 16'hFFFF -> 0

## Operation
- Opcodes:
  - 3'b000 AND
  - 3'b001 OR
  - 3'b010 NOR
  - 3'b011 INV(OP1)
  - 3'b100 INV(OP2)
  - 3'b101 PASS(OP1)
  - 3'b110/3'b111 illegal: result 0, ZERO=1, ERR=1
- Accept = IN_VALID & IN_READY. Pop = OUT_VALID & OUT_READY.
- Queue states EMPTY, ONE, TWO, held as a 2-bit count with head/tail entries:
  - EMPTY: accept -> ONE.
  - ONE: accept only -> TWO; pop only -> EMPTY; accept and pop together -> ONE, with the new entry becoming head.
  - TWO: no accept possible; pop -> ONE, with the tail moving to head.
- IN_READY = (count != TWO) & ~RST. It is a function of registered state only and has no combinational path from OUT_READY.
- While OUT_VALID=1 and OUT_READY=0, RESULT/ZERO/ERR remain stable.
- OP_COUNT increments on every accept, including illegal opcodes.
- OPRN/OP1/OP2 are don't-care when IN_VALID=0.

## Timing
- Reset (RST high at a rising edge) clears:
  - count to EMPTY
  - OUT_VALID=0, RESULT=0, ZERO=0, ERR=0
  - OP_COUNT=0
  - IN_READY=0 while RST is high; IN_READY=1 in the first cycle after RST falls.
- Reset mid-operation discards all queued entries; nothing is emitted afterwards.
- Latency: an entry accepted at edge N is visible on OUT_VALID/RESULT after edge N when the queue was EMPTY. If older entries are queued, it appears after they pop.
- Throughput: 1 op/cycle while OUT_READY is held high.
- With OUT_READY low, two accepts fill the queue; IN_READY drops after the second accept edge.
- Ordering is strictly FIFO. No entry is ever dropped or duplicated.

## Structure
- Opcode constants (LOGIC_AND … LOGIC_PASS_A) and the queue depth constant belong in the shared definitions file (prj_definition.v) alongside the existing ALU opcodes.
- Sub-module: instantiate the existing 32-bit gate arrays (NOR32_2x1, AND32_2x1, OR32_2x1, two INV32_1x1) directly.
- A natural single sub-module is logic_result_queue: the 2-entry skid FIFO carrying {ERR, ZERO, RESULT}.
- The op mux and zero detect stay in the top level.

## Test plan
- Reset: assert RST for 2 cycles mid-stream with 2 entries queued -> OUT_VALID=0, RESULT=0, OP_COUNT=0, IN_READY=0 during reset and 1 the cycle after.
- Logic ops with OUT_READY=1 and OP1=0x0a17b980, OP2=0x11af6077, one per cycle:
  - AND -> 0x00072000
  - OR -> 0x1bbff9f7
  - NOR -> 0xe4400608
  - each result appears one cycle after accept, in order.
- Zero/invert: INV(OP1) with OP1=0xffffffff -> RESULT=0x00000000, ZERO=1; INV(OP2) with OP2=0x00000000 -> 0xffffffff, ZERO=0.
- Backpressure: hold OUT_READY=0 and offer 3 ops -> 2 accepted, IN_READY=0, RESULT stable. Release OUT_READY -> both results drain in order, then the third is accepted.
- Simultaneous accept and pop in state ONE -> count stays ONE, the new result is head on the next cycle, OP_COUNT increments by 1.
- Illegal OPRN=3'b111 -> RESULT=0, ZERO=1, ERR=1. Then OP_COUNT wraps from 0xFFFF to 0x0000 on the next accept (preload via a long run or force).
